mide_hazard_scoreboard: RTL and testbench

- Parametrised scoreboard that replaces the fixed distance-compare stall/forward logic in the mide pipeline.
- Tracks every in-flight register write with a countdown to write-back, so producers may have variable latency (multi-cycle vector ops).
- Per decode-stage source it produces a stall request and a forward-tap select; it also detects WAW hazards and supports a pipeline flush.
- Sits beside the ID stage; queried with the sources/destination of the instruction in ID.

---
 rtl/mide_sb_pkg.sv | 17 +
 rtl/sb_entry.sv | 52 +++++
 rtl/mide_hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_mide_hazard_scoreboard.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mide_sb_pkg.sv
// Shared constants and width helpers for the mide hazard scoreboard.
package mide_sb_pkg;

  // Forward-select value meaning "read the register file, no bypass".
  localparam int FSEL_RF = 0;

  // Width of a countdown able to hold 0..max_lat.
  function automatic int lat_w(input int max_lat);
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

  // Width of a forward select able to hold 0..fwd_depth.
  function automatic int fsel_w(input int fwd_depth);
    return (fwd_depth < 1) ? 1 : $clog2(fwd_depth + 1);
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One tracked register: pending flag plus countdown to write-back.
module sb_entry #(
  parameter int LAT_W      = 3,
  parameter int FLUSH_KEEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_cnt_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [LAT_W-1:0] cnt_o
);

  localparam logic [LAT_W-1:0] KEEP_C = LAT_W'(FLUSH_KEEP);
  localparam logic [LAT_W-1:0] ONE_C  = LAT_W'(1);

  logic             busy_q, busy_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  // Next state: a new issue overrides everything, then flush-kill of young
  // entries, otherwise a pending entry counts down and retires at zero.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      busy_d = 1'b1;
      cnt_d  = load_cnt_i;
    end else if (flush_i && (cnt_q > KEEP_C)) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      cnt_d  = cnt_q - ONE_C;
      busy_d = (cnt_q != ONE_C);
    end
  end

  // Entry state flops; reset drops any in-flight write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/mide_hazard_scoreboard.sv
// Register-write scoreboard for the ID stage: per-source stall / forward-tap
// select, WAW rejection, flush of young writes and a stalled-cycle counter.
//
// Issue handshake: issue_valid is the request, issue_accept the grant. The
// write is recorded on the edge where both are high; a rejected request is
// not remembered, so ID holds the instruction (stall) and re-presents it.
module mide_hazard_scoreboard
  import mide_sb_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_SRC    = 2,
  parameter int MAX_LAT    = 4,
  parameter int FWD_DEPTH  = 2,
  parameter int FLUSH_KEEP = 2,
  parameter int ZERO_REG   = 1,
  localparam int LAT_W     = lat_w(MAX_LAT),
  localparam int FSEL_W    = fsel_w(FWD_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [ADDR_W-1:0]           issue_rd,
  input  logic [LAT_W-1:0]            issue_lat,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  input  logic                        flush,
  output logic                        stall,
  output logic                        issue_accept,
  output logic [NUM_SRC*FSEL_W-1:0]   fwd_sel,
  output logic [NUM_REGS-1:0]         busy_vec,
  output logic [31:0]                 stall_count
);

  localparam logic [LAT_W-1:0] MAX_C = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] FWD_C = LAT_W'(FWD_DEPTH);

  logic [NUM_REGS-1:0] busy;
  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] load_vec;
  logic [LAT_W-1:0]    lat_eff;
  logic                rd_busy, rd_zero, waw, src_stall;
  logic [LAT_W-1:0]    rd_cnt;
  logic [31:0]         stall_count_q, stall_count_d;

  // State of the destination register being issued.
  always_comb begin
    rd_busy = 1'b0;
    rd_cnt  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (issue_rd == ADDR_W'(r)) begin
        rd_busy = busy[r];
        rd_cnt  = cnt[r];
      end
    end
  end

  // Per-source hazard: far producers stall, near ones select a bypass tap.
  always_comb begin
    logic             s_busy;
    logic [LAT_W-1:0] s_cnt;
    logic [ADDR_W-1:0] s_addr;
    src_stall = 1'b0;
    fwd_sel   = '0;
    s_busy    = 1'b0;
    s_cnt     = '0;
    s_addr    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_addr = src_addr[i*ADDR_W +: ADDR_W];
      s_busy = 1'b0;
      s_cnt  = '0;
      fwd_sel[i*FSEL_W +: FSEL_W] = FSEL_W'(FSEL_RF);
      for (int r = 0; r < NUM_REGS; r++) begin
        if (s_addr == ADDR_W'(r)) begin
          s_busy = busy[r];
          s_cnt  = cnt[r];
        end
      end
      if (src_valid[i] && s_busy && !((ZERO_REG != 0) && (s_addr == '0))) begin
        if (s_cnt > FWD_C) src_stall = 1'b1;
        else fwd_sel[i*FSEL_W +: FSEL_W] = FSEL_W'(s_cnt);
      end
    end
  end

  // Issue arbitration: clamp latency, detect WAW, decide accept and stall.
  always_comb begin
    lat_eff      = (issue_lat > MAX_C) ? MAX_C : issue_lat;
    waw          = rd_busy && (lat_eff < rd_cnt);
    rd_zero      = (ZERO_REG != 0) && (issue_rd == '0);
    stall        = src_stall || (issue_valid && waw);
    issue_accept = issue_valid && (lat_eff != '0) && !stall && !flush &&
                   !waw && !rd_zero;
    for (int r = 0; r < NUM_REGS; r++) begin
      load_vec[r] = issue_accept && (issue_rd == ADDR_W'(r));
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_entry
      sb_entry #(
        .LAT_W      (LAT_W),
        .FLUSH_KEEP (FLUSH_KEEP)
      ) u_entry (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_vec[g]),
        .load_cnt_i (lat_eff),
        .flush_i    (flush),
        .busy_o     (busy[g]),
        .cnt_o      (cnt[g])
      );
    end
  endgenerate

  // Saturating stalled-cycle count.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
  end

  // Counter flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign busy_vec    = busy;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_mide_hazard_scoreboard.sv
// Directed bench for mide_hazard_scoreboard: a driver pushes hand-computed
// expectations per cycle, a monitor pops and compares them.
module tb_mide_hazard_scoreboard;

  localparam int EXP_W = 70;

  typedef struct packed {
    logic        stall;
    logic        acc;
    logic [3:0]  fsel;
    logic [31:0] busy;
    logic [31:0] sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [2:0]  issue_lat = '0;
  logic [1:0]  src_valid = '0;
  logic [9:0]  src_addr = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        issue_accept;
  logic [3:0]  fwd_sel;
  logic [31:0] busy_vec;
  logic [31:0] stall_count;

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  event chk_ev;

  mide_hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_lat    (issue_lat),
    .src_valid    (src_valid),
    .src_addr     (src_addr),
    .flush        (flush),
    .stall        (stall),
    .issue_accept (issue_accept),
    .fwd_sel      (fwd_sel),
    .busy_vec     (busy_vec),
    .stall_count  (stall_count)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic es, input logic ea, input logic [3:0] ef,
                      input logic [31:0] eb, input logic [31:0] ec);
    exp_t e;
    e.stall = es; e.acc = ea; e.fsel = ef; e.busy = eb; e.sc = ec;
    exp_q.push_back(EXP_W'(e));
  endtask

  // Driver: one cycle of inputs plus the outputs expected in that cycle.
  task automatic step(input logic iv, input logic [4:0] rd, input logic [2:0] lat,
                      input logic [1:0] sv, input logic [4:0] a0, input logic [4:0] a1,
                      input logic fl, input logic es, input logic ea,
                      input logic [3:0] ef, input logic [31:0] eb, input logic [31:0] ec);
    @(posedge clk);
    #1;
    issue_valid = iv; issue_rd = rd; issue_lat = lat;
    src_valid = sv; src_addr = {a1, a0}; flush = fl;
    push(es, ea, ef, eb, ec);
  endtask

  // Monitor: compares on the falling edge, or at once for async checks.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        chk("stall",        {31'd0, stall},        {31'd0, e.stall});
        chk("issue_accept", {31'd0, issue_accept}, {31'd0, e.acc});
        chk("fwd_sel",      {28'd0, fwd_sel},      {28'd0, e.fsel});
        chk("busy_vec",     busy_vec,              e.busy);
        chk("stall_count",  stall_count,           e.sc);
      end
    end
  end

  // Stimulus
  initial begin
    // reset state while rst is held
    #2;
    push(0, 0, 4'h0, 32'h0, 0);
    ->chk_ev;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //   iv rd    lat  sv     a0    a1    fl  stall acc fsel  busy         sc
    step(0, 5'd0, 3'd0, 2'b01, 5'd5, 5'd0, 0,  0,   0,  4'h0, 32'h0,       0);
    // r5 latency 4: two stalled cycles, then taps 2 and 1, then retired
    step(1, 5'd5, 3'd4, 2'b01, 5'd5, 5'd0, 0,  0,   1,  4'h0, 32'h0,       0);
    step(0, 5'd0, 3'd0, 2'b01, 5'd5, 5'd0, 0,  1,   0,  4'h0, 32'h20,      0);
    step(0, 5'd0, 3'd0, 2'b01, 5'd5, 5'd0, 0,  1,   0,  4'h0, 32'h20,      1);
    step(0, 5'd0, 3'd0, 2'b11, 5'd5, 5'd5, 0,  0,   0,  4'hA, 32'h20,      2);
    step(0, 5'd0, 3'd0, 2'b01, 5'd5, 5'd0, 0,  0,   0,  4'h1, 32'h20,      2);
    step(0, 5'd0, 3'd0, 2'b01, 5'd5, 5'd0, 0,  0,   0,  4'h0, 32'h0,       2);
    // WAW on r7: shorter latency rejected, equal-or-longer reloads
    step(1, 5'd7, 3'd4, 2'b00, 5'd0, 5'd0, 0,  0,   1,  4'h0, 32'h0,       2);
    step(1, 5'd7, 3'd3, 2'b00, 5'd0, 5'd0, 0,  1,   0,  4'h0, 32'h80,      2);
    step(1, 5'd7, 3'd4, 2'b00, 5'd0, 5'd0, 0,  0,   1,  4'h0, 32'h80,      3);
    step(0, 5'd0, 3'd0, 2'b01, 5'd7, 5'd0, 0,  1,   0,  4'h0, 32'h80,      3);
    step(0, 5'd0, 3'd0, 2'b01, 5'd7, 5'd0, 0,  1,   0,  4'h0, 32'h80,      4);
    step(0, 5'd0, 3'd0, 2'b01, 5'd7, 5'd0, 0,  0,   0,  4'h2, 32'h80,      5);
    step(0, 5'd0, 3'd0, 2'b00, 5'd0, 5'd0, 0,  0,   0,  4'h0, 32'h80,      5);
    // flush: r3 (cnt 4) dies, r4 (cnt 2) survives, issue of r9 dropped
    step(1, 5'd4, 3'd3, 2'b00, 5'd0, 5'd0, 0,  0,   1,  4'h0, 32'h0,       5);
    step(1, 5'd3, 3'd4, 2'b00, 5'd0, 5'd0, 0,  0,   1,  4'h0, 32'h10,      5);
    step(1, 5'd9, 3'd2, 2'b00, 5'd0, 5'd0, 1,  0,   0,  4'h0, 32'h18,      5);
    step(0, 5'd0, 3'd0, 2'b11, 5'd4, 5'd3, 0,  0,   0,  4'h1, 32'h10,      5);
    // register 0 never tracked, latency 0 ignored, latency 7 clamps to 4
    step(1, 5'd0, 3'd3, 2'b11, 5'd0, 5'd0, 0,  0,   0,  4'h0, 32'h0,       5);
    step(1, 5'd6, 3'd0, 2'b01, 5'd0, 5'd0, 0,  0,   0,  4'h0, 32'h0,       5);
    step(1, 5'd6, 3'd7, 2'b00, 5'd0, 5'd0, 0,  0,   1,  4'h0, 32'h0,       5);
    step(0, 5'd0, 3'd0, 2'b01, 5'd6, 5'd0, 0,  1,   0,  4'h0, 32'h40,      5);
    step(0, 5'd0, 3'd0, 2'b01, 5'd6, 5'd0, 0,  1,   0,  4'h0, 32'h40,      6);
    step(0, 5'd0, 3'd0, 2'b01, 5'd6, 5'd0, 0,  0,   0,  4'h2, 32'h40,      7);
    // issue blocked by a source stall while r8 keeps counting down
    step(1, 5'd8, 3'd4, 2'b00, 5'd0, 5'd0, 0,  0,   1,  4'h0, 32'h40,      7);
    step(1, 5'd2, 3'd4, 2'b01, 5'd8, 5'd0, 0,  1,   0,  4'h0, 32'h100,     7);
    step(1, 5'd2, 3'd4, 2'b01, 5'd8, 5'd0, 0,  1,   0,  4'h0, 32'h100,     8);
    step(1, 5'd2, 3'd4, 2'b01, 5'd8, 5'd0, 0,  0,   1,  4'h2, 32'h100,     9);
    step(0, 5'd0, 3'd0, 2'b11, 5'd8, 5'd2, 0,  1,   0,  4'h1, 32'h104,     9);
    step(0, 5'd0, 3'd0, 2'b00, 5'd0, 5'd0, 0,  0,   0,  4'h0, 32'h4,       10);

    // asynchronous reset mid-countdown, checked before any clock edge
    @(posedge clk);
    #1;
    src_valid = 2'b01; src_addr = {5'd0, 5'd2}; issue_valid = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #1;
    push(0, 0, 4'h0, 32'h0, 0);
    ->chk_ev;
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 5'd0, 3'd0, 2'b01, 5'd2, 5'd0, 0,  0,   0,  4'h0, 32'h0,       0);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
